// File: rtl/rds_pkg.sv
// rds_pkg: RDS generator polynomial, offset words, block ids and decoder state.
// Shared between the RDS mixer encoder and the receive-side decoder.
package rds_pkg;

  localparam logic [10:0] G_POLY = 11'h5B9;
  localparam logic [9:0]  G_LOW  = G_POLY[9:0];

  localparam logic [9:0] OFS_A  = 10'h0FC;
  localparam logic [9:0] OFS_B  = 10'h198;
  localparam logic [9:0] OFS_C  = 10'h168;
  localparam logic [9:0] OFS_CP = 10'h350;
  localparam logic [9:0] OFS_D  = 10'h1B4;

  localparam logic [2:0] ID_A  = 3'd0;
  localparam logic [2:0] ID_B  = 3'd1;
  localparam logic [2:0] ID_C  = 3'd2;
  localparam logic [2:0] ID_CP = 3'd3;
  localparam logic [2:0] ID_D  = 3'd4;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_PRESYNC,
    ST_SYNC
  } state_e;

  // x^n mod g(x), folded to a constant row at each call site
  function automatic logic [9:0] x_pow_mod(input int n);
    logic [9:0] r;
    r = 10'h001;
    for (int k = 0; k < 25; k++) begin
      if (k < n) begin
        r = r[9] ? ({r[8:0], 1'b0} ^ G_LOW)
                 : {r[8:0], 1'b0};
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] match_offset(
    input logic [9:0] r
  );
    logic [3:0] m;
    unique case (1'b1)
      (r == OFS_A):  m = {1'b1, ID_A};
      (r == OFS_B):  m = {1'b1, ID_B};
      (r == OFS_C):  m = {1'b1, ID_C};
      (r == OFS_CP): m = {1'b1, ID_CP};
      (r == OFS_D):  m = {1'b1, ID_D};
      default:       m = 4'b0;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] id_pos(
    input logic [2:0] id
  );
    logic [1:0] p;
    case (id)
      ID_B:        p = 2'd1;
      ID_C, ID_CP: p = 2'd2;
      ID_D:        p = 2'd3;
      default:     p = 2'd0;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] pos_id(
    input logic [1:0] p
  );
    logic [2:0] id;
    case (p)
      2'd1:    id = ID_B;
      2'd2:    id = ID_C;
      2'd3:    id = ID_D;
      default: id = ID_A;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/rds_syndrome.sv
// rds_syndrome: 26-bit block to 10-bit remainder modulo g(x).
// Each set bit contributes its precomputed x^i mod g(x) row.
module rds_syndrome
  import rds_pkg::*;
(
  input  logic [25:0] win,
  output logic [9:0]  syn
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < 26; i++) begin
      if (win[i]) syn = syn ^ x_pow_mod(i);
    end
  end

endmodule

// File: rtl/rds_decoder.sv
// rds_decoder: RDS block sync by syndrome matching, block and group output.
// Decisions use the window including the bit arriving this cycle.
module rds_decoder
  import rds_pkg::*;
#(
  parameter int MAX_BAD = 8
) (
  input  logic        clk_25m,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] blk_data,
  output logic [2:0]  blk_id,
  output logic        blk_ok,
  output logic        blk_valid,
  output logic [63:0] group_data,
  output logic        group_ver_b,
  output logic        group_valid,
  output logic        synced
);

  localparam int BW = $clog2(MAX_BAD + 1);

  state_e        state, state_nx;
  logic [24:0]   hist;
  logic [25:0]   win;
  logic [9:0]    syn;
  logic [4:0]    bit_cnt, cnt_nx;
  logic [1:0]    exp_pos, pos_nx;
  logic [BW-1:0] bad_cnt, bad_nx, bad_inc;
  logic          hit, exp_ok, last;
  logic [2:0]    hit_id, dec_id;
  logic          dec, dec_ok;
  logic [15:0]   grp_a, grp_b, grp_c;
  logic          grp_ok, grp_ver;

  assign win = {hist, bit_in};

  rds_syndrome u_syn (
    .win (win),
    .syn (syn)
  );

  assign {hit, hit_id} = match_offset(syn);
  assign exp_ok  = hit && (id_pos(hit_id) == exp_pos);
  assign last    = (bit_cnt == 5'd25);
  assign bad_inc = bad_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    pos_nx   = exp_pos;
    bad_nx   = bad_cnt;
    dec      = 1'b0;
    dec_ok   = 1'b0;
    dec_id   = pos_id(exp_pos);
    if (bit_valid) begin
      unique case (state)
        ST_SEARCH: begin
          if (hit) begin
            state_nx = ST_PRESYNC;
            cnt_nx   = '0;
            pos_nx   = id_pos(hit_id) + 2'd1;
          end
        end
        ST_PRESYNC: begin
          cnt_nx = last ? 5'd0 : bit_cnt + 5'd1;
          if (last) begin
            state_nx = ST_SEARCH;
            if (exp_ok) begin
              state_nx = ST_SYNC;
              dec      = 1'b1;
              dec_ok   = 1'b1;
              dec_id   = hit_id;
              pos_nx   = exp_pos + 2'd1;
              bad_nx   = '0;
            end
          end
        end
        ST_SYNC: begin
          cnt_nx = last ? 5'd0 : bit_cnt + 5'd1;
          if (last) begin
            dec    = 1'b1;
            pos_nx = exp_pos + 2'd1;
            if (exp_ok) begin
              dec_ok = 1'b1;
              dec_id = hit_id;
              bad_nx = '0;
            end else if (bad_inc == BW'(MAX_BAD)) begin
              state_nx = ST_SEARCH;
              bad_nx   = '0;
            end else begin
              bad_nx = bad_inc;
            end
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SEARCH;
      hist        <= '0;
      bit_cnt     <= '0;
      exp_pos     <= '0;
      bad_cnt     <= '0;
      blk_data    <= '0;
      blk_id      <= '0;
      blk_ok      <= 1'b0;
      blk_valid   <= 1'b0;
      group_data  <= '0;
      group_ver_b <= 1'b0;
      group_valid <= 1'b0;
      synced      <= 1'b0;
      grp_a       <= '0;
      grp_b       <= '0;
      grp_c       <= '0;
      grp_ok      <= 1'b0;
      grp_ver     <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= cnt_nx;
      exp_pos     <= pos_nx;
      bad_cnt     <= bad_nx;
      blk_valid   <= dec;
      group_valid <= 1'b0;
      synced      <= (state_nx == ST_SYNC);
      if (bit_valid) hist <= win[24:0];
      // a group picked up mid-stream stays invalid until the next A
      if (state == ST_SEARCH) grp_ok <= 1'b0;
      if (dec) begin
        blk_data <= win[25:10];
        blk_id   <= dec_id;
        blk_ok   <= dec_ok;
        case (id_pos(dec_id))
          2'd0: begin
            grp_a  <= win[25:10];
            grp_ok <= dec_ok;
          end
          2'd1: begin
            grp_b  <= win[25:10];
            grp_ok <= grp_ok & dec_ok;
          end
          2'd2: begin
            grp_c   <= win[25:10];
            grp_ver <= (dec_id == ID_CP);
            grp_ok  <= grp_ok & dec_ok;
          end
          default: begin
            if (grp_ok && dec_ok) begin
              group_data  <= {grp_a, grp_b, grp_c, win[25:10]};
              group_ver_b <= grp_ver;
              group_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rds_decoder.sv
// tb_rds_decoder: encoded RDS streams against a block-level reference model.
// Table-driven group vectors plus sync-loss, false-match and reset sequences.
module tb_rds_decoder;

  logic        clk_25m = 1'b0;
  logic        reset_n;
  logic        bit_in;
  logic        bit_valid;
  logic [15:0] blk_data;
  logic [2:0]  blk_id;
  logic        blk_ok;
  logic        blk_valid;
  logic [63:0] group_data;
  logic        group_ver_b;
  logic        group_valid;
  logic        synced;

  always #20 clk_25m = ~clk_25m;

  rds_decoder #(.MAX_BAD(8)) dut (
    .clk_25m     (clk_25m),
    .reset_n     (reset_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .blk_data    (blk_data),
    .blk_id      (blk_id),
    .blk_ok      (blk_ok),
    .blk_valid   (blk_valid),
    .group_data  (group_data),
    .group_ver_b (group_ver_b),
    .group_valid (group_valid),
    .synced      (synced)
  );

  int checks = 0;
  int failures = 0;
  int gv_cnt = 0;
  int bv_cnt = 0;
  int gap_max = 0;
  logic [63:0] last_gd;
  logic        last_ver;

  logic [25:0] m_win;
  int          m_state, m_cnt, m_pos, m_bad;
  logic [15:0] m_gw [4];
  bit          m_gok, m_gver;
  logic [15:0] m_blk_data;
  logic [2:0]  m_blk_id;
  bit          m_blk_ok, m_blk_valid;
  logic [63:0] m_gdata;
  bit          m_gver_b, m_gvalid, m_synced;

  typedef struct {
    logic [15:0] a, b, c, d;
    bit          ver;
    int          flip;
    bit          exp_gv;
  } gvec_t;

  gvec_t tbl [7];

  function automatic logic [9:0] ofs_of(input int i);
    case (i)
      0: return 10'h0FC;
      1: return 10'h198;
      2: return 10'h168;
      3: return 10'h350;
      default: return 10'h1B4;
    endcase
  endfunction

  function automatic logic [9:0] syn_ref(input logic [25:0] v);
    logic [25:0] t;
    t = v;
    for (int i = 25; i >= 10; i--)
      if (t[i]) t[i-:11] = t[i-:11] ^ 11'h5B9;
    return t[9:0];
  endfunction

  function automatic int find_id(input logic [9:0] r);
    for (int i = 0; i < 5; i++)
      if (r == ofs_of(i)) return i;
    return -1;
  endfunction

  function automatic int pos_of(input int id);
    return (id == 3) ? 2 : (id == 4) ? 3 : id;
  endfunction

  function automatic logic [25:0] enc(input logic [15:0] w,
                                      input logic [9:0] o);
    return {w, syn_ref({w, 10'b0}) ^ o};
  endfunction

  // no offset match in any window before the block is complete
  function automatic bit pre_ok(input logic [6:0] p,
                                input logic [25:0] a);
    logic [25:0] w;
    bit          b;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      b = (k < 7) ? p[6-k] : a[25-(k-7)];
      w = {w[24:0], b};
      if (find_id(syn_ref(w)) >= 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_win = '0; m_state = 0; m_cnt = 0; m_pos = 0; m_bad = 0;
    for (int i = 0; i < 4; i++) m_gw[i] = '0;
    m_gok = 0; m_gver = 0;
    m_blk_data = '0; m_blk_id = '0; m_blk_ok = 0; m_blk_valid = 0;
    m_gdata = '0; m_gver_b = 0; m_gvalid = 0; m_synced = 0;
  endtask

  task automatic model_emit(input int id, input bit ok,
                            input logic [15:0] d);
    int p;
    p = pos_of(id);
    m_blk_valid = 1; m_blk_data = d; m_blk_id = id[2:0]; m_blk_ok = ok;
    m_gw[p] = d;
    if (p == 0) m_gok = ok;
    else m_gok = m_gok & ok;
    if (p == 2) m_gver = (id == 3);
    if (p == 3 && m_gok) begin
      m_gvalid = 1;
      m_gdata  = {m_gw[0], m_gw[1], m_gw[2], d};
      m_gver_b = m_gver;
    end
  endtask

  task automatic model_step(input bit b);
    int id;
    bit ok;
    m_blk_valid = 0; m_gvalid = 0;
    m_win = {m_win[24:0], b};
    id = find_id(syn_ref(m_win));
    if (m_state == 0) begin
      if (id >= 0) begin
        m_state = 1; m_cnt = 0; m_pos = (pos_of(id) + 1) % 4;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 26) begin
        m_cnt = 0;
        ok = (id >= 0) && (pos_of(id) == m_pos);
        if (m_state == 1) begin
          if (ok) begin
            model_emit(id, 1, m_win[25:10]);
            m_state = 2; m_bad = 0; m_pos = (m_pos + 1) % 4;
          end else begin
            m_state = 0; m_gok = 0;
          end
        end else begin
          if (ok) begin
            m_bad = 0;
            model_emit(id, 1, m_win[25:10]);
          end else begin
            m_bad++;
            model_emit((m_pos == 3) ? 4 : m_pos, 0, m_win[25:10]);
            if (m_bad == 8) begin
              m_state = 0; m_bad = 0; m_gok = 0;
            end
          end
          m_pos = (m_pos + 1) % 4;
        end
      end
    end
    m_synced = (m_state == 2);
  endtask

  function automatic logic [87:0] act_vec();
    return {blk_data, blk_id, blk_ok, blk_valid, group_data,
            group_ver_b, group_valid, synced};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs();
    chk("outputs", act_vec(),
        {m_blk_data, m_blk_id, m_blk_ok, m_blk_valid, m_gdata,
         m_gver_b, m_gvalid, m_synced});
    if (blk_valid) bv_cnt++;
    if (group_valid) begin
      gv_cnt++;
      last_gd  = group_data;
      last_ver = group_ver_b;
    end
  endtask

  task automatic tick(input bit v, input bit b);
    @(negedge clk_25m);
    check_outs();
    bit_valid = v;
    bit_in = v ? b : 1'($urandom);
    if (v) model_step(b);
    else begin
      m_blk_valid = 0;
      m_gvalid = 0;
    end
  endtask

  task automatic send_bit(input bit b);
    tick(1'b1, b);
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick(1'b0, 1'b0);
  endtask

  task automatic settle();
    tick(1'b0, 1'b0);
  endtask

  task automatic send_block(input logic [15:0] w, input int oi,
                            input int flip);
    logic [25:0] cw;
    cw = enc(w, ofs_of(oi));
    if (flip >= 0) cw[25-flip] = ~cw[25-flip];
    for (int i = 25; i >= 0; i--) send_bit(cw[i]);
  endtask

  task automatic send_group(input gvec_t g, input int fbit);
    send_block(g.a, 0, (g.flip == 0) ? fbit : -1);
    send_block(g.b, 1, (g.flip == 1) ? fbit : -1);
    send_block(g.c, g.ver ? 3 : 2, (g.flip == 2) ? fbit : -1);
    send_block(g.d, 4, (g.flip == 3) ? fbit : -1);
  endtask

  task automatic pulse_reset();
    @(negedge clk_25m);
    check_outs();
    reset_n = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("reset_clear", act_vec(), 0);
    model_reset();
    @(negedge clk_25m);
    reset_n = 1'b1;
  endtask

  initial begin
    gvec_t       g;
    logic [6:0]  pre;
    logic [25:0] a_cw, r26;
    logic [15:0] w;
    int          gv0, bv0, tries;

    tbl[0] = '{16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 1'b0, -1, 1'b1};
    tbl[1] = '{16'h1234, 16'h0408, 16'h1234, 16'h4142, 1'b1, -1, 1'b1};
    tbl[2] = '{16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 1'b0,  2, 1'b0};
    tbl[3] = '{16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 1'b0, -1, 1'b1};
    tbl[4] = '{16'hBEEF, 16'h2000, 16'h5555, 16'h0000, 1'b1, -1, 1'b1};
    tbl[5] = '{16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 1'b0,  0, 1'b0};
    tbl[6] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001, 1'b0, -1, 1'b1};

    model_reset();
    reset_n = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clk_25m);
    chk("reset_state", act_vec(), 0);
    reset_n = 1'b1;

    // clean start: 7-bit preamble, sync after the 2nd block
    gap_max = 3;
    a_cw = enc(16'h1234, ofs_of(0));
    tries = 0;
    do begin
      pre = 7'($urandom);
      tries++;
    end while (!pre_ok(pre, a_cw) && tries < 1000);
    for (int i = 6; i >= 0; i--) send_bit(pre[i]);
    gv0 = gv_cnt;
    send_block(16'h1234, 0, -1);
    settle();
    chk("synced_after_a", synced, 0);
    send_block(16'h0408, 1, -1);
    settle();
    chk("synced_after_b", synced, 1);
    chk("first_blk_id", blk_id, 1);
    send_block(16'hE0CD, 2, -1);
    send_block(16'h4142, 4, -1);
    settle();
    chk("partial_group_gv", gv_cnt - gv0, 0);

    for (int i = 0; i < 7; i++) begin
      gv0 = gv_cnt;
      send_group(tbl[i], 5);
      settle();
      chk($sformatf("tbl%0d_gv", i), gv_cnt - gv0, tbl[i].exp_gv);
      if (tbl[i].exp_gv) begin
        chk($sformatf("tbl%0d_data", i), last_gd,
            {tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d});
        chk($sformatf("tbl%0d_ver", i), last_ver, tbl[i].ver);
      end
    end

    // random groups with occasional single-bit errors
    for (int n = 0; n < 20; n++) begin
      g.a = 16'($urandom); g.b = 16'($urandom);
      g.c = 16'($urandom); g.d = 16'($urandom);
      g.ver = 1'($urandom);
      g.flip = (n < 19 && $urandom_range(0, 2) == 0)
               ? int'($urandom_range(0, 3)) : -1;
      g.exp_gv = 1'b0;
      send_group(g, int'($urandom_range(0, 25)));
    end

    // eight consecutive bad blocks drop sync on the eighth
    gap_max = 2;
    for (int i = 0; i < 8; i++) begin
      send_block(16'h1111 * i[15:0], (i % 4 == 3) ? 4 : i % 4, 5);
      settle();
      if (i == 6) chk("synced_after_7_bad", synced, 1);
    end
    chk("synced_after_8_bad", synced, 0);
    chk("bad8_blk_ok", blk_ok, 0);
    chk("bad8_blk_id", blk_id, 4);
    gv0 = gv_cnt;
    for (int i = 0; i < 3; i++) send_group(tbl[0], -1);
    settle();
    chk("resync", synced, 1);
    chk("resync_gv", (gv_cnt - gv0) >= 1, 1);

    // reset mid-block, then reacquire with back-to-back strobes
    gap_max = 0;
    for (int i = 25; i > 15; i--) send_bit(a_cw[i]);
    pulse_reset();
    gv0 = gv_cnt;
    for (int i = 0; i < 3; i++) send_group(tbl[0], -1);
    settle();
    chk("reacq_synced", synced, 1);
    chk("reacq_gv", (gv_cnt - gv0) >= 1, 1);
    chk("reacq_data", last_gd, 64'h12340408E0CD4142);

    // false A match in SEARCH followed by a non-B block
    pulse_reset();
    tries = 0;
    do begin
      w = 16'($urandom);
      tries++;
    end while (!pre_ok(7'd0, enc(w, ofs_of(0))) && tries < 1000);
    do r26 = 26'($urandom); while (syn_ref(r26) == ofs_of(1));
    bv0 = bv_cnt;
    send_block(w, 0, -1);
    for (int i = 25; i >= 0; i--) send_bit(r26[i]);
    settle();
    chk("false_match_blk_valid", bv_cnt - bv0, 0);
    chk("false_match_synced", synced, 0);

    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rds_decoder.md
# rds_decoder

Receive-side counterpart of the RDS mixer: recovers RDS blocks and groups from the demodulated RDS bitstream. Sits downstream of the 57 kHz / biphase demodulator (bit strobe at 1187.5 bit/s) and upstream of station-info logic (PI/PS/RT parsing). Performs block synchronisation by syndrome matching, tracks sync loss, and emits checked 16-bit blocks and complete 64-bit groups.

## Interface
- MAX_BAD, 8, consecutive bad blocks in SYNC before sync is dropped
- clk_25m  in  1  system clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- bit_in  in  1  received data bit, valid with bit_valid
- bit_valid  in  1  one-cycle strobe per received bit; may assert on consecutive cycles
- blk_data  out  16  information word of last decided block
- blk_id  out  3  0=A, 1=B, 2=C, 3=C', 4=D
- blk_ok  out  1  last decided block syndrome matched expected offset
- blk_valid  out  1  one-cycle pulse: blk_data/blk_id/blk_ok updated
- group_data  out  64  {A,B,C|C',D} information words
- group_ver_b  out  1  group used C' (version B)
- group_valid  out  1  one-cycle pulse: complete error-free group
- synced  out  1  high in SYNC state

## Operation
- Bits arrive MSB first; 26-bit shift register `win` shifts left on bit_valid, new bit into win[0].
- Syndrome r = win(x) mod g(x), g(x)=x^10+x^8+x^7+x^5+x^4+x^3+1; r is 10 bits. Block matches offset O when r == O: A=0x0FC, B=0x198, C=0x168, C'=0x350, D=0x1B4.
- States: SEARCH, PRESYNC, SYNC.
- SEARCH: after every bit, if r matches any offset, record its id, set expected next id (A→B→C/C'→D→A), bit_cnt=0, go PRESYNC. No blk_valid output.
- PRESYNC: after 26 more bits, if r matches the expected offset → SYNC and emit that block (blk_ok=1); else → SEARCH (bit_cnt cleared, search resumes next bit).
- SYNC: every 26th bit decide one block. Expected id position 2 accepts C or C'; blk_id reports which. Match: blk_ok=1, bad_cnt=0. No match: blk_ok=0, blk_id=expected (C reported as 2), bad_cnt+1; if bad_cnt reaches MAX_BAD → SEARCH, synced=0. Position always advances regardless of match.
- blk_data = win[25:10] at decision.
- Group assembly: on A decision, clear group-good flag then set it to blk_ok; each later block ANDs blk_ok and stores its word. On D decision with flag set: group_data, group_ver_b updated, group_valid pulses. A group entered mid-stream (sync acquired on B/C/D) never produces group_valid until the next A.
- No error correction; burst-correction is out of scope.

## Timing
- Reset values: all outputs 0; state SEARCH; win, bit_cnt, bad_cnt, group regs 0.
- Decision latency: blk_valid, group_valid pulse exactly 1 cycle after the bit_valid cycle that shifted in the 26th bit; outputs registered.
- group_valid coincides with the D block's blk_valid.
- synced rises with the PRESYNC-confirming blk_valid; falls in the cycle the MAX_BAD-th bad block's blk_valid pulses (that blk_valid still issued, blk_ok=0).
- bit_valid back-to-back each cycle fully supported; no bit lost.
- reset_n assertion mid-block: immediate clear, partial block discarded, no pulses.
- bit_in ignored when bit_valid=0.

## Structure
- Package rds_pkg: g(x) constant, the five offset words, blk_id encodings, state enum; shared with the rds mixer encoder.
- Sub-module rds_syndrome: combinational 26-bit → 10-bit remainder (XOR of per-bit precomputed rows), reusable by the encoder's checkword generation.
- Top rds_decoder: shift register, FSM, counters, group assembly.

## Test plan
- Clean stream: bench-encoded groups PI=0x1234, B=0x0408, C=0xE0CD, D=0x4142 repeated, preceded by 7 random bits → synced after 2nd block, group_valid with group_data=0x12340408E0CD4142, group_ver_b=0.
- Version B: C' offset with C=0x1234 → blk_id=3, group_ver_b=1, group_valid pulses.
- Single bit flip in one C block while synced → that blk_ok=0, no group_valid for that group, bad_cnt recovers, next group valid.
- 8 consecutive corrupted blocks → synced drops on 8th blk_valid; clean stream resumes → resync within 2 blocks after alignment.
- False match in SEARCH (random bits crafted to match A, next 26 bits not B) → returns to SEARCH, synced stays 0, no blk_valid.
- reset_n pulsed mid-block while synced → all outputs 0 next cycle, reacquires from SEARCH; bit_valid every cycle throughout gives identical results to sparse strobes.
